imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 256, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter LEN_W, default 9, meaning width of load_len and word_count; it must satisfy 2^LEN_W > MEM_SIZE.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port load_start, input, 1 bit: one-cycle request to begin a program load.
REQ-006 SHALL have port load_len, input, LEN_W bits: number of words to load, sampled with load_start.
REQ-007 SHALL have port byte_valid, input, 1 bit: byte_data is valid this cycle.
REQ-008 SHALL have port byte_data, input, 8 bits: incoming program byte.
REQ-009 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-010 SHALL have port cpu_addr, input, 32 bits: CPU fetch byte address (PC).
REQ-011 SHALL have port mem_addr, output, 32 bits: byte address presented to instruction memory.
REQ-012 SHALL have port mem_we, output, 1 bit: instruction memory write enable.
REQ-013 SHALL have port mem_wdata, output, 32 bits: word written to instruction memory.
REQ-014 SHALL have port cpu_hold, output, 1 bit: CPU held (PC frozen, no fetch) while high.
REQ-015 SHALL have port load_done, output, 1 bit: one-cycle pulse when a load completes.
REQ-016 SHALL have port load_err, output, 1 bit: one-cycle pulse when load_start is rejected.
REQ-017 SHALL have port word_count, output, LEN_W bits: words written in the current or last load.

Function
REQ-018 SHALL implement FSM states IDLE, RECV, WRITE and DONE.
REQ-019 In IDLE, load_start with 1 <= load_len <= MEM_SIZE SHALL latch load_len, clear word_count and the byte index, and go to RECV next cycle.
REQ-020 In IDLE, load_start with load_len = 0 or load_len > MEM_SIZE SHALL pulse load_err for 1 cycle and remain in IDLE.
REQ-021 load_start SHALL be ignored outside IDLE.
REQ-022 byte_ready SHALL be 1 only in RECV; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-023 Bytes SHALL be assembled big-endian: 1st accepted byte to bits 31:24, 2nd to 23:16, 3rd to 15:8, 4th to 7:0.
REQ-024 Acceptance of the 4th byte SHALL move the FSM to WRITE on the next cycle.
REQ-025 In WRITE (exactly 1 cycle), the block SHALL drive mem_we=1, mem_addr=word_count*4 and mem_wdata=the assembled word, and increment word_count.
REQ-026 From WRITE, if the incremented word_count equals the latched length the FSM SHALL go to DONE; otherwise it SHALL return to RECV with the byte index at 0.
REQ-027 DONE SHALL last 1 cycle, pulse load_done=1, then return to IDLE.
REQ-028 cpu_hold SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-029 When cpu_hold=0, mem_addr SHALL equal cpu_addr combinationally and mem_we SHALL be 0.
REQ-030 In RECV and DONE, mem_addr SHALL be word_count*4 and mem_we SHALL be 0.
REQ-031 mem_wdata SHALL be 0 whenever mem_we=0.
REQ-032 byte_valid gaps SHALL stall assembly indefinitely with no timeout; the partial word and byte index SHALL be held.
REQ-033 word_count SHALL hold its final value in IDLE until the next accepted load_start.

Reset
REQ-034 While reset=1 at a clock edge, the block SHALL enter IDLE and clear word_count, the byte index, the assembled word and the latched length.
REQ-035 After reset, outputs SHALL be: byte_ready=0, mem_we=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, word_count=0, mem_addr=cpu_addr.
REQ-036 Reset SHALL take priority over load_start and byte acceptance in the same cycle.
REQ-037 Reset mid-load SHALL discard any partial word, issue no write, and drop cpu_hold the following cycle.

Verification
REQ-038 Bench SHALL cover: load_len=1, bytes 8'h20,8'h08,8'h00,8'h05 back-to-back -> one cycle with mem_we=1, mem_addr=0, mem_wdata=32'h20080005; load_done next cycle; word_count=1.
REQ-039 Bench SHALL cover: load_len=3, 12 bytes with random byte_valid gaps -> writes to addresses 0, 4 and 8 in order; cpu_hold=1 from the cycle after load_start until DONE exits.
REQ-040 Bench SHALL cover: load_start with load_len=0, and with load_len=257 -> load_err pulses 1 cycle each, cpu_hold stays 0, no mem_we.
REQ-041 Bench SHALL cover: reset asserted after 6 bytes of a 2-word load -> exactly one write (address 0), FSM in IDLE, cpu_hold=0, word_count=0.
REQ-042 Bench SHALL cover: IDLE with cpu_addr=32'h0000_0010 -> mem_addr=32'h0000_0010, mem_we=0; load_start asserted during RECV -> ignored.
REQ-043 Bench SHALL cover: load_len=256 full load -> last write at mem_addr=32'h3FC, word_count=256, then load_done.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory one byte at a time
// and holds the CPU until the requested number of words has been written.
//
// Ports
//   clk, reset        : single rising-edge clock, synchronous active-high reset
//   load_start        : one-cycle load request, load_len sampled with it
//   load_len          : number of 32-bit words to load (1..MEM_SIZE)
//   byte_valid/data   : incoming program byte stream
//   byte_ready        : loader accepts a byte this cycle (RECV only)
//   cpu_addr          : CPU fetch byte address, passed through while idle
//   mem_addr/we/wdata : instruction memory write/fetch port
//   cpu_hold          : CPU frozen while a load is in progress
//   load_done         : one-cycle pulse when the last word has been written
//   load_err          : one-cycle pulse when a load request is rejected
//   word_count        : words written in the current or last load
module imem_loader #(
  parameter int unsigned MEM_SIZE = 256,
  parameter int unsigned LEN_W    = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic [31:0]      cpu_addr,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [LEN_W-1:0] word_count
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    word_count_q, word_count_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                load_err_q, load_err_d;

  logic                len_ok_c;
  logic                byte_acc_c;
  logic [LEN_W-1:0]    count_inc_c;
  logic [WORD_W-1:0]   count_addr_c;

  // Request qualification, handshake and address helpers.
  always_comb begin
    len_ok_c     = (load_len != '0) && (32'(load_len) <= MEM_SIZE);
    byte_acc_c   = (state_q == RECV) && byte_valid;
    count_inc_c  = word_count_q + LEN_W'(1);
    count_addr_c = WORD_W'(word_count_q) << 2;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_count_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      load_err_q   <= load_err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    load_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          if (len_ok_c) begin
            len_d        = load_len;
            word_count_d = '0;
            byte_idx_d   = '0;
            word_d       = '0;
            state_d      = RECV;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end

      RECV: begin
        // Shifting left places the first byte of a word in bits 31:24.
        if (byte_acc_c) begin
          word_d     = {word_q[WORD_W-9:0], byte_data};
          byte_idx_d = byte_idx_q + IDX_W'(1);
          if (byte_idx_q == IDX_W'(3)) begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        word_count_d = count_inc_c;
        byte_idx_d   = '0;
        state_d      = (count_inc_c == len_q) ? DONE : RECV;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; mem_addr passes cpu_addr straight through when idle.
  always_comb begin
    byte_ready = (state_q == RECV);
    cpu_hold   = (state_q != IDLE);
    mem_we     = (state_q == WRITE);
    mem_wdata  = (state_q == WRITE) ? word_q : '0;
    mem_addr   = (state_q == IDLE) ? cpu_addr : count_addr_c;
    load_done  = (state_q == DONE);
    load_err   = load_err_q;
    word_count = word_count_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: reset state, a table of load requests,
// directed multi-cycle sequences and randomized loads checked against a
// transaction-level model (expected write list built from the byte stream).
module tb_imem_loader;

  localparam int unsigned MEM_SIZE = 256;
  localparam int unsigned LEN_W    = 9;

  logic             clk;
  logic             reset;
  logic             load_start;
  logic [LEN_W-1:0] load_len;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic [31:0]      cpu_addr;
  logic [31:0]      mem_addr;
  logic             mem_we;
  logic [31:0]      mem_wdata;
  logic             cpu_hold;
  logic             load_done;
  logic             load_err;
  logic [LEN_W-1:0] word_count;

  imem_loader #(.MEM_SIZE(MEM_SIZE), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .cpu_addr   (cpu_addr),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks;
  int          n_fail;
  int          done_cnt;
  int          err_cnt;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  prog[$];

  typedef struct {
    int   len;
    logic exp_err;
  } start_vec_t;

  start_vec_t vecs[8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Advance one cycle, then sample outputs and apply the always-true rules.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end else begin
      check32("wdata_zero_when_no_we", mem_wdata, 32'h0);
    end
    if (cpu_hold === 1'b0) begin
      check32("idle_addr_passthru", mem_addr, cpu_addr);
      check1("idle_no_we", mem_we, 1'b0);
    end
    if (load_done === 1'b1) done_cnt++;
    if (load_err === 1'b1) err_cnt++;
  endtask

  task automatic gen_prog(input int len);
    prog.delete();
    for (int i = 0; i < 4 * len; i++) prog.push_back(8'($urandom));
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
  endfunction

  task automatic verify_writes(input int len);
    check32("write_count", wr_addr.size(), len);
    for (int i = 0; i < wr_addr.size() && i < len; i++) begin
      check32("write_addr", wr_addr[i], 4 * i);
      check32("write_data", wr_data[i], model_word(i));
    end
  endtask

  // Full load with random byte_valid gaps; optional ignored load_start noise.
  task automatic run_load(input int len, input int gap_pct, input bit noise);
    int idx;
    int budget;
    int err0;
    bit rdy;
    idx    = 0;
    budget = 20 * len + 40;
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    load_start = 1'b1;
    load_len   = LEN_W'(len);
    tick();
    load_start = 1'b0;
    err0 = err_cnt;
    while (load_done !== 1'b1 && budget > 0) begin
      check1("hold_during_load", cpu_hold, 1'b1);
      if (idx < prog.size() && $urandom_range(99) >= gap_pct) begin
        byte_valid = 1'b1;
        byte_data  = prog[idx];
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
      load_start = noise ? 1'($urandom) : 1'b0;
      load_len   = LEN_W'($urandom);
      cpu_addr   = $urandom;
      rdy = byte_ready;
      tick();
      if (byte_valid && rdy) idx++;
      budget--;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    check1("load_done_seen", load_done, 1'b1);
    check1("hold_in_done", cpu_hold, 1'b1);
    check32("word_count_final", 32'(word_count), len);
    tick();
    check1("hold_released", cpu_hold, 1'b0);
    check1("done_one_cycle", load_done, 1'b0);
    check32("word_count_held", 32'(word_count), len);
    check32("single_done", done_cnt, 1);
    check32("no_err_during_load", err_cnt - err0, 0);
    verify_writes(len);
  endtask

  task automatic bad_start(input int len);
    int err0;
    err0 = err_cnt;
    load_start = 1'b1;
    load_len   = LEN_W'(len);
    tick();
    load_start = 1'b0;
    check1("err_pulse", load_err, 1'b1);
    check1("err_no_hold", cpu_hold, 1'b0);
    tick();
    check1("err_one_cycle", load_err, 1'b0);
    check1("err_stays_idle", cpu_hold, 1'b0);
    check32("err_pulse_count", err_cnt - err0, 1);
  endtask

  initial begin
    int fed;
    int budget;
    bit rdy;
    n_checks = 0; n_fail = 0; done_cnt = 0; err_cnt = 0;
    reset = 1'b1; load_start = 1'b0; load_len = '0;
    byte_valid = 1'b0; byte_data = '0; cpu_addr = 32'hDEAD_BEEF;

    vecs[0] = '{0,   1'b1};
    vecs[1] = '{1,   1'b0};
    vecs[2] = '{2,   1'b0};
    vecs[3] = '{255, 1'b0};
    vecs[4] = '{256, 1'b0};
    vecs[5] = '{257, 1'b1};
    vecs[6] = '{300, 1'b1};
    vecs[7] = '{511, 1'b1};

    // Reset state.
    tick();
    tick();
    check1("rst_byte_ready", byte_ready, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    check1("rst_cpu_hold", cpu_hold, 1'b0);
    check1("rst_load_done", load_done, 1'b0);
    check1("rst_load_err", load_err, 1'b0);
    check32("rst_word_count", 32'(word_count), 32'h0);
    check32("rst_mem_addr", mem_addr, 32'hDEAD_BEEF);
    reset = 1'b0;
    tick();

    // Table of load requests: rejected ones pulse load_err, accepted ones hold.
    for (int v = 0; v < 8; v++) begin
      load_start = 1'b1;
      load_len   = LEN_W'(vecs[v].len);
      tick();
      load_start = 1'b0;
      check1("vec_err", load_err, vecs[v].exp_err);
      check1("vec_hold", cpu_hold, ~vecs[v].exp_err);
      check1("vec_ready", byte_ready, ~vecs[v].exp_err);
      check1("vec_no_we", mem_we, 1'b0);
      tick();
      check1("vec_err_cleared", load_err, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check1("vec_abort_hold", cpu_hold, 1'b0);
    end

    // Single-word load, bytes back-to-back, cycle-exact.
    prog.delete();
    prog.push_back(8'h20); prog.push_back(8'h08);
    prog.push_back(8'h00); prog.push_back(8'h05);
    wr_addr.delete(); wr_data.delete();
    load_start = 1'b1; load_len = LEN_W'(1);
    tick();
    load_start = 1'b0;
    byte_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      byte_data = prog[k];
      tick();
    end
    byte_valid = 1'b0;
    check1("w1_we", mem_we, 1'b1);
    check32("w1_addr", mem_addr, 32'h0);
    check32("w1_data", mem_wdata, 32'h2008_0005);
    check1("w1_hold", cpu_hold, 1'b1);
    tick();
    check1("w1_done", load_done, 1'b1);
    check1("w1_we_off", mem_we, 1'b0);
    check32("w1_wc", 32'(word_count), 32'd1);
    tick();
    check1("w1_idle", cpu_hold, 1'b0);
    check1("w1_done_off", load_done, 1'b0);
    check32("w1_writes", wr_addr.size(), 1);

    // Three words with random gaps.
    gen_prog(3);
    run_load(3, 40, 1'b0);

    // Rejected lengths.
    bad_start(0);
    bad_start(257);

    // Idle pass-through and load_start ignored in RECV.
    cpu_addr = 32'h0000_0010;
    #1;
    check32("idle_addr_0x10", mem_addr, 32'h0000_0010);
    check1("idle_we_0x10", mem_we, 1'b0);
    load_start = 1'b1; load_len = LEN_W'(2);
    tick();
    load_len = LEN_W'(0);
    tick();
    load_start = 1'b0;
    check1("recv_start_no_err", load_err, 1'b0);
    check1("recv_start_hold", cpu_hold, 1'b1);
    check1("recv_start_ready", byte_ready, 1'b1);

    // Reset after six bytes of a two-word load.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    gen_prog(2);
    wr_addr.delete(); wr_data.delete();
    load_start = 1'b1; load_len = LEN_W'(2);
    tick();
    load_start = 1'b0;
    fed = 0;
    budget = 40;
    while (fed < 6 && budget > 0) begin
      byte_valid = 1'b1;
      byte_data  = prog[fed];
      rdy = byte_ready;
      tick();
      if (rdy) fed++;
      budget--;
    end
    byte_valid = 1'b0;
    check32("rst_mid_bytes_fed", fed, 6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("rst_mid_hold", cpu_hold, 1'b0);
    check1("rst_mid_ready", byte_ready, 1'b0);
    check32("rst_mid_wc", 32'(word_count), 32'h0);
    tick();
    check32("rst_mid_writes", wr_addr.size(), 1);
    if (wr_addr.size() > 0) begin
      check32("rst_mid_addr", wr_addr[0], 32'h0);
      check32("rst_mid_data", wr_data[0], model_word(0));
    end

    // Reset wins over a valid load_start in the same cycle.
    reset = 1'b1; load_start = 1'b1; load_len = LEN_W'(4);
    tick();
    reset = 1'b0; load_start = 1'b0;
    tick();
    check1("rst_prio_hold", cpu_hold, 1'b0);

    // Full-depth load.
    gen_prog(256);
    run_load(256, 20, 1'b0);
    if (wr_addr.size() == 256) check32("full_last_addr", wr_addr[255], 32'h0000_03FC);

    // Randomized mix of rejected and accepted loads.
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) bad_start(0);
        else bad_start(int'($urandom_range(511, 257)));
      end else begin
        int len;
        len = int'($urandom_range(6, 1));
        gen_prog(len);
        run_load(len, int'($urandom_range(50)), 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
